// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state encoding, HD44780 command bytes and 100 MHz timing defaults
package lcd_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_HI_E, ST_HI_L, ST_LO_E, ST_LO_L, ST_WAIT} state_e;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_FUNC_4BIT = 8'h28;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_ENTRY     = 8'h06;
  localparam logic [7:0] CMD_LINE2     = 8'hC0;
  localparam int T_E_HIGH_DEF    = 5000;
  localparam int T_E_LOW_DEF     = 5000;
  localparam int T_EXEC_DEF      = 5000;
  localparam int T_EXEC_LONG_DEF = 200000;
  localparam int CNT_W_DEF       = 24;
  // Clear Display and Return Home (0x02/0x03) need the long execution wait
  function automatic logic is_long(input logic [7:0] d, input logic rs, input logic nib);
    return !rs && !nib && (d == CMD_CLEAR || d[7:1] == CMD_HOME[7:1]);
  endfunction
endpackage

// File: rtl/lcd_byte_writer_if.sv
// lcd_byte_writer_if: byte request handshake between the sequencer and the writer
interface lcd_byte_writer_if;
  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic       rs;
  logic       nibble_only;
  logic       done;
  modport master(output valid, data, rs, nibble_only, input ready, done);
  modport slave(input valid, data, rs, nibble_only, output ready, done);
endinterface

// File: rtl/lcd_phase_timer.sv
// lcd_phase_timer: restartable up-counter flagging the last cycle of a phase of limit_i cycles
module lcd_phase_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             done_o
);
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk) cnt_q <= (rst || load_i) ? '0 : cnt_q + CNT_W'(1);
  assign done_o = cnt_q == limit_i - CNT_W'(1);
endmodule

// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer: sends one byte (or high nibble) to an HD44780 4-bit bus with E strobes and exec waits
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int T_E_HIGH    = T_E_HIGH_DEF,
  parameter int T_E_LOW     = T_E_LOW_DEF,
  parameter int T_EXEC      = T_EXEC_DEF,
  parameter int T_EXEC_LONG = T_EXEC_LONG_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  lcd_byte_writer_if.slave    bus,
  output logic [3:0]          o_lcd_db,
  output logic                o_lcd_e,
  output logic                o_lcd_rs,
  output logic                o_lcd_rw
);
  state_e           state_q;
  logic [7:0]       data_q;
  logic             nib_q, long_q, e_q, rs_q, done_q;
  logic [3:0]       db_q;
  logic [CNT_W-1:0] limit;
  logic             t_done;
  always_comb begin
    limit = (state_q == ST_HI_E || state_q == ST_LO_E) ? CNT_W'(T_E_HIGH) :
            (state_q == ST_HI_L || state_q == ST_LO_L) ? CNT_W'(T_E_LOW) :
            long_q ? CNT_W'(T_EXEC_LONG) : CNT_W'(T_EXEC);
  end
  // Held cleared while idle so every phase starts counting from zero on entry
  lcd_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (state_q == ST_IDLE || t_done),
    .limit_i(limit),
    .done_o (t_done)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      nib_q   <= 1'b0;
      long_q  <= 1'b0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      db_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (bus.valid) begin
          state_q <= ST_HI_E;
          data_q  <= bus.data;
          nib_q   <= bus.nibble_only;
          long_q  <= is_long(bus.data, bus.rs, bus.nibble_only);
          rs_q    <= bus.rs;
          db_q    <= bus.data[7:4];
          e_q     <= 1'b1;
        end
        ST_HI_E: if (t_done) begin
          state_q <= ST_HI_L;
          e_q     <= 1'b0;
        end
        ST_HI_L: if (t_done) begin
          state_q <= nib_q ? ST_WAIT : ST_LO_E;
          e_q     <= !nib_q;
          db_q    <= nib_q ? db_q : data_q[3:0];
        end
        ST_LO_E: if (t_done) begin
          state_q <= ST_LO_L;
          e_q     <= 1'b0;
        end
        ST_LO_L: if (t_done) state_q <= ST_WAIT;
        ST_WAIT: if (t_done) begin
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign bus.ready = state_q == ST_IDLE;
  assign bus.done  = done_q;
  assign o_lcd_db  = db_q;
  assign o_lcd_e   = e_q;
  assign o_lcd_rs  = rs_q;
  assign o_lcd_rw  = 1'b0;
endmodule

// File: tb/tb_lcd_byte_writer.sv
// tb_lcd_byte_writer: directed and random byte/nibble transfers checked cycle by cycle against a timing model
module tb_lcd_byte_writer;
  localparam int TH = 3, TL = 2, TX = 4, TXL = 10;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] lcd_db;
  logic lcd_e, lcd_rs, lcd_rw;
  logic [3:0] last_db;
  logic last_rs;
  int total = 0, bad = 0;
  lcd_byte_writer_if bus ();
  lcd_byte_writer #(.T_E_HIGH(TH), .T_E_LOW(TL), .T_EXEC(TX), .T_EXEC_LONG(TXL), .CNT_W(24)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_lcd_db(lcd_db),
    .o_lcd_e (lcd_e),
    .o_lcd_rs(lcd_rs),
    .o_lcd_rw(lcd_rw)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_e", 32'(lcd_e), 32'(0));
      chk("idle_done", 32'(bus.done), 32'(0));
      chk("idle_ready", 32'(bus.ready), 32'(1));
      chk("idle_db", 32'(lcd_db), 32'(last_db));
      chk("idle_rs", 32'(lcd_rs), 32'(last_rs));
      chk("idle_rw", 32'(lcd_rw), 32'(0));
    end
  endtask
  // Called just after the accept edge; checks every cycle through the o_done cycle
  task automatic xfer_check(input logic [7:0] d, input logic r, input logic n);
    int w, tot;
    logic e_x;
    logic [3:0] db_x;
    w   = (!n && !r && d >= 8'd1 && d <= 8'd3) ? TXL : TX;
    tot = (n ? 1 : 2) * (TH + TL) + w;
    db_x = d[7:4];
    for (int c = 1; c <= tot + 1; c++) begin
      @(negedge clk);
      e_x  = (c <= TH) || (!n && c > TH + TL && c <= 2 * TH + TL);
      db_x = (!n && c > TH + TL) ? d[3:0] : d[7:4];
      chk("e", 32'(lcd_e), 32'(e_x));
      chk("db", 32'(lcd_db), 32'(db_x));
      chk("rs", 32'(lcd_rs), 32'(r));
      chk("rw", 32'(lcd_rw), 32'(0));
      chk("ready", 32'(bus.ready), 32'(c == tot + 1));
      chk("done", 32'(bus.done), 32'(c == tot + 1));
    end
    last_db = db_x;
    last_rs = r;
  endtask
  task automatic send(input logic [7:0] d, input logic r, input logic n);
    @(negedge clk);
    chk("ready_pre", 32'(bus.ready), 32'(1));
    bus.valid = 1'b1;
    bus.data = d;
    bus.rs = r;
    bus.nibble_only = n;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    bus.data = 8'($urandom);
    bus.rs = 1'($urandom);
    bus.nibble_only = 1'($urandom);
    xfer_check(d, r, n);
  endtask
  initial begin
    logic [7:0] d;
    logic r, n;
    bus.valid = 1'b0;
    bus.data = '0;
    bus.rs = 1'b0;
    bus.nibble_only = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_db = '0;
    last_rs = 1'b0;
    idle(1);
    send(8'h46, 1'b1, 1'b0);
    send(8'h30, 1'b0, 1'b1);
    send(8'h01, 1'b0, 1'b0);
    send(8'h01, 1'b1, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b0);
    send(8'h28, 1'b0, 1'b0);
    send(8'h01, 1'b0, 1'b1);
    // valid held high: the second byte is taken in the o_done cycle
    @(negedge clk);
    bus.valid = 1'b1;
    bus.data = 8'h41;
    bus.rs = 1'b1;
    bus.nibble_only = 1'b0;
    @(posedge clk);
    #1 bus.data = 8'h42;
    xfer_check(8'h41, 1'b1, 1'b0);
    @(posedge clk);
    #1 bus.valid = 1'b0;
    xfer_check(8'h42, 1'b1, 1'b0);
    // reset while the low nibble strobe is high
    @(negedge clk);
    bus.valid = 1'b1;
    bus.data = 8'h46;
    bus.rs = 1'b1;
    bus.nibble_only = 1'b0;
    @(posedge clk);
    #1 bus.valid = 1'b0;
    repeat (TH + TL + 1) @(negedge clk);
    chk("rst_pre_e", 32'(lcd_e), 32'(1));
    chk("rst_pre_db", 32'(lcd_db), 32'(6));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_e", 32'(lcd_e), 32'(0));
    chk("rst_db", 32'(lcd_db), 32'(0));
    chk("rst_rs", 32'(lcd_rs), 32'(0));
    chk("rst_ready", 32'(bus.ready), 32'(1));
    chk("rst_done", 32'(bus.done), 32'(0));
    last_db = '0;
    last_rs = 1'b0;
    idle(100);
    for (int k = 0; k < 30; k++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(1, 3));
      r = 1'($urandom_range(0, 1));
      n = ($urandom_range(0, 3) == 0);
      idle($urandom_range(0, 3));
      send(d, r, n);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
